wb_regfile: RTL
===============

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter BYPASS, default 1; 1 enables same-cycle write-to-read forwarding on both read ports, 0 disables it.
REQ-002 Parameter CNT_W, default 32; width of the retire counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 wm2reg  input  1  writeback source select: 1 = memory data, 0 = ALU result.
REQ-006 wwreg  input  1  writeback enable from the W stage.
REQ-007 wmo  input  32  memory load data from the W stage.
REQ-008 walu  input  32  ALU result from the W stage.
REQ-009 wrn  input  5  destination register number from the W stage.
REQ-010 rna  input  5  read port A register number (decode stage).
REQ-011 rnb  input  5  read port B register number (decode stage).
REQ-012 qa  output  32  read port A data, combinational.
REQ-013 qb  output  32  read port B data, combinational.
REQ-014 wdata  output  32  selected writeback value, combinational: wm2reg ? wmo : walu.
REQ-015 wb_valid  output  1  registered; 1 for one cycle after each committed write with wrn != 0.
REQ-016 instret  output  CNT_W  registered count of committed writebacks.

Function
REQ-017 Storage SHALL be 31 x 32-bit registers x1..x31; x0 is not stored.
REQ-018 Write SHALL occur at a rising clk edge when wwreg=1 and wrn!=0: reg[wrn] <= wdata.
REQ-019 Writes with wrn=0 SHALL be discarded; no state other than instret changes.
REQ-020 Reads of register 0 SHALL return 32'h0 on qa/qb regardless of BYPASS or pending write.
REQ-021 With BYPASS=1: if wwreg=1, wrn!=0 and rna==wrn, qa SHALL equal wdata in the same cycle; same rule for qb/rnb.
REQ-022 With BYPASS=0: qa/qb SHALL return the stored value; a write becomes visible the cycle after the edge.
REQ-023 Both read ports SHALL be independent; rna==rnb SHALL return identical data on qa and qb.
REQ-024 Simultaneous write and read of the same register on both ports SHALL apply REQ-021/022 to each port identically.
REQ-025 wb_valid SHALL be 1 in the cycle following an edge where wwreg=1 and wrn!=0, else 0.
REQ-026 instret SHALL increment by 1 at every edge with wwreg=1, including wrn=0 (retired instruction with discarded result).
REQ-027 instret SHALL wrap modulo 2^CNT_W: all-ones + 1 -> 0, no flag.
REQ-028 Write latency 1 edge; read latency 0 (combinational); no stall or handshake inputs.
REQ-029 X on wm2reg/wmo/walu while wwreg=0 SHALL NOT alter stored state.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear x1..x31 to 0, wb_valid to 0, instret to 0.
REQ-031 While rst_n=0, writes SHALL be blocked; qa/qb SHALL read 0 for stored registers, and with BYPASS=1 a matching wrn may still forward wdata combinationally.
REQ-032 Reset asserted mid-write SHALL win; deassertion takes effect at the next rising edge without any partial write.

Verification
REQ-033 Reset, then rna=5, rnb=31 -> qa=0, qb=0, instret=0, wb_valid=0.
REQ-034 wwreg=1, wrn=7, wm2reg=0, walu=32'h1234_5678 for one edge; next cycle rna=7 -> qa=32'h1234_5678, wb_valid=1, instret=1.
REQ-035 wwreg=1, wrn=9, wm2reg=1, wmo=32'hDEAD_BEEF, walu=32'h1, rna=rnb=9 same cycle, BYPASS=1 -> qa=qb=32'hDEAD_BEEF before the edge; BYPASS=0 -> old value before, new value after.
REQ-036 wwreg=1, wrn=0, walu=32'hFFFF_FFFF; rna=0 -> qa=0 same and next cycle, wb_valid=0, instret increments by 1.
REQ-037 Preload instret near wrap (CNT_W=4, 15 writes) then one more write -> instret=0.
REQ-038 Write x3=32'hA5A5_A5A5, then pulse rst_n low between edges -> qa(rna=3)=0 immediately, instret=0, wb_valid=0.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback-stage register file: 31 x 32-bit registers (x0 hard-wired to zero),
// two combinational read ports with optional same-cycle write forwarding,
// a one-cycle commit strobe and a retired-writeback counter.
module wb_regfile #(
  parameter int unsigned BYPASS = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wm2reg,
  input  logic             wwreg,
  input  logic [31:0]      wmo,
  input  logic [31:0]      walu,
  input  logic [4:0]       wrn,
  input  logic [4:0]       rna,
  input  logic [4:0]       rnb,
  output logic [31:0]      qa,
  output logic [31:0]      qb,
  output logic [31:0]      wdata,
  output logic             wb_valid,
  output logic [CNT_W-1:0] instret
);

  logic [31:0] regs [1:31];
  logic        wr_en;

  assign wdata = wm2reg ? wmo : walu;
  assign wr_en = wwreg && (wrn != 5'd0);

  // Register storage: async clear, write x1..x31 only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wrn] <= wdata;
    end
  end

  // Read port A: x0 reads zero, optional forwarding of the pending write
  always_comb begin
    qa = '0;
    if (rna != 5'd0) begin
      if ((BYPASS != 0) && wr_en && (rna == wrn)) qa = wdata;
      else                                        qa = regs[rna];
    end
  end

  // Read port B: identical rules to port A
  always_comb begin
    qb = '0;
    if (rnb != 5'd0) begin
      if ((BYPASS != 0) && wr_en && (rnb == wrn)) qb = wdata;
      else                                        qb = regs[rnb];
    end
  end

  // Commit strobe and retire counter; wrn=0 writebacks still retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      instret  <= '0;
    end else begin
      wb_valid <= wr_en;
      if (wwreg) instret <= instret + CNT_W'(1);
    end
  end

endmodule
